// File: rtl/exec_unit_if.sv
// Issue and writeback bundle between an upstream issuer and exec_unit.
interface exec_unit_if;
  logic       issue_valid;
  logic       issue_ready;
  logic [2:0] op;
  logic [3:0] rd;
  logic [7:0] a;
  logic [7:0] b;
  logic       wb_we;
  logic [3:0] wb_sel;
  logic [7:0] wb_data;
  logic       flag_z;
  logic       flag_c;
  logic       busy;

  modport master (
    output issue_valid, op, rd, a, b,
    input  issue_ready, wb_we, wb_sel, wb_data, flag_z, flag_c, busy
  );
  modport slave (
    input  issue_valid, op, rd, a, b,
    output issue_ready, wb_we, wb_sel, wb_data, flag_z, flag_c, busy
  );
endinterface

// File: rtl/exec_unit.sv
// Single-issue 8-bit execution unit: one-cycle ALU ops, iterative shift-add MUL.
module exec_unit #(
  parameter int MUL_CYCLES = 8
) (
  input logic         clk,
  input logic         rst_n,
  exec_unit_if.slave  io
);
  localparam int CW = $clog2(MUL_CYCLES);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_MUL = 3'd7;

  typedef enum logic [1:0] {IDLE, WB, MUL} state_t;

  state_t        state;
  logic [15:0]   mcand;
  logic [15:0]   prod;
  logic [7:0]    mplier;
  logic [CW-1:0] cnt;
  logic [3:0]    rd_q;

  logic          accept;
  logic [7:0]    alu_res;
  logic          alu_c;
  logic [8:0]    sum9;
  logic [8:0]    diff9;
  logic [15:0]   shl16;
  logic [15:0]   shr16;
  logic [15:0]   prod_nxt;

  assign io.issue_ready = (state != MUL);
  assign io.busy        = (state == MUL);
  assign io.wb_we       = (state == WB);
  assign accept         = io.issue_valid && io.issue_ready;

  // Shifts run in a 16-bit window so the last bit shifted out lands at a fixed position.
  always_comb begin
    sum9    = {1'b0, io.a} + {1'b0, io.b};
    diff9   = {1'b0, io.a} - {1'b0, io.b};
    shl16   = {8'h00, io.a} << io.b[2:0];
    shr16   = {io.a, 8'h00} >> io.b[2:0];
    alu_res = 8'h00;
    alu_c   = 1'b0;
    case (io.op)
      OP_ADD: begin alu_res = sum9[7:0];  alu_c = sum9[8];  end
      OP_SUB: begin alu_res = diff9[7:0]; alu_c = diff9[8]; end
      OP_AND: alu_res = io.a & io.b;
      OP_OR:  alu_res = io.a | io.b;
      OP_XOR: alu_res = io.a ^ io.b;
      OP_SHL: begin alu_res = shl16[7:0];  alu_c = shl16[8]; end
      OP_SHR: begin alu_res = shr16[15:8]; alu_c = shr16[7]; end
      default: ;
    endcase
  end

  assign prod_nxt = prod + (mplier[0] ? mcand : 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      io.wb_sel  <= 4'h0;
      io.wb_data <= 8'h00;
      io.flag_z  <= 1'b0;
      io.flag_c  <= 1'b0;
      mcand      <= 16'h0000;
      prod       <= 16'h0000;
      mplier     <= 8'h00;
      cnt        <= '0;
      rd_q       <= 4'h0;
    end else begin
      case (state)
        IDLE, WB: begin
          if (accept && io.op == OP_MUL) begin
            state  <= MUL;
            mcand  <= {8'h00, io.a};
            mplier <= io.b;
            prod   <= 16'h0000;
            cnt    <= '0;
            rd_q   <= io.rd;
          end else if (accept) begin
            state      <= WB;
            io.wb_sel  <= io.rd;
            io.wb_data <= alu_res;
            io.flag_z  <= (alu_res == 8'h00);
            io.flag_c  <= alu_c;
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Last multiplier bit folds in on the same edge that enters WB.
          if (cnt == CW'(MUL_CYCLES - 1)) begin
            state      <= WB;
            io.wb_sel  <= rd_q;
            io.wb_data <= prod_nxt[7:0];
            io.flag_z  <= (prod_nxt[7:0] == 8'h00);
            io.flag_c  <= |prod_nxt[15:8];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// Directed + random bench for exec_unit with a writeback scoreboard.
module tb_exec_unit;
  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] data;
    logic       z;
    logic       c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  exec_unit_if io();
  exec_unit #(.MUL_CYCLES(8)) dut (.clk(clk), .rst_n(rst_n), .io(io.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [3:0] r,
                                 input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  v;
    logic        c;
    v = 8'h00; c = 1'b0;
    case (o)
      3'd0: begin s = x + y; v = s[7:0]; c = s[8]; end
      3'd1: begin v = x - y; c = (x < y); end
      3'd2: v = x & y;
      3'd3: v = x | y;
      3'd4: v = x ^ y;
      3'd5: begin v = x; for (int i = 0; i < int'(y[2:0]); i++) begin c = v[7]; v = v << 1; end end
      3'd6: begin v = x; for (int i = 0; i < int'(y[2:0]); i++) begin c = v[0]; v = v >> 1; end end
      default: begin p = x * y; v = p[7:0]; c = (p > 16'd255); end
    endcase
    e.sel = r; e.data = v; e.z = (v == 8'h00); e.c = c;
    return e;
  endfunction

  // Drives an op at a negedge, holds it until accepted; w = cycles spent waiting.
  task automatic issue(input logic [2:0] o, input logic [3:0] r, input logic [7:0] x,
                       input logic [7:0] y, input bit push, input exp_t e, output int w);
    @(negedge clk);
    io.issue_valid = 1'b1; io.op = o; io.rd = r; io.a = x; io.b = y;
    w = 0;
    while (!io.issue_ready && w < 50) begin @(negedge clk); w++; end
    check("issue_accept_timeout", {31'd0, io.issue_ready}, 32'd1);
    @(posedge clk);
    if (push) sb.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    io.issue_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (io.wb_we === 1'b1) begin
      if (sb.size() == 0) check("spurious_wb", {31'd0, io.wb_we}, 32'd0);
      else begin
        e = sb.pop_front();
        check("wb_sel",  {28'd0, io.wb_sel},  {28'd0, e.sel});
        check("wb_data", {24'd0, io.wb_data}, {24'd0, e.data});
        check("flag_z",  {31'd0, io.flag_z},  {31'd0, e.z});
        check("flag_c",  {31'd0, io.flag_c},  {31'd0, e.c});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    exp_t e;
    logic [2:0] ro;
    logic [7:0] ra, rb;
    io.issue_valid = 1'b0; io.op = 3'd0; io.rd = 4'd0; io.a = 8'd0; io.b = 8'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_wb_we",  {31'd0, io.wb_we},       32'd0);
    check("rst_wb_sel", {28'd0, io.wb_sel},      32'd0);
    check("rst_wb_data",{24'd0, io.wb_data},     32'd0);
    check("rst_flag_z", {31'd0, io.flag_z},      32'd0);
    check("rst_flag_c", {31'd0, io.flag_c},      32'd0);
    check("rst_busy",   {31'd0, io.busy},        32'd0);
    check("rst_ready",  {31'd0, io.issue_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ADD wrap with carry, one-cycle writeback pulse
    issue(3'd0, 4'd3, 8'd200, 8'd100, 1, '{sel:4'd3, data:8'd44, z:1'b0, c:1'b1}, w);
    @(negedge clk); io.issue_valid = 1'b0;
    check("add_wb_we_hi", {31'd0, io.wb_we}, 32'd1);
    @(negedge clk);
    check("add_wb_we_lo", {31'd0, io.wb_we}, 32'd0);
    check("flag_c_hold",  {31'd0, io.flag_c}, 32'd1);

    // back-to-back SUBs
    issue(3'd1, 4'd1, 8'd5, 8'd5, 1, '{sel:4'd1, data:8'd0, z:1'b1, c:1'b0}, w);
    issue(3'd1, 4'd2, 8'd2, 8'd3, 1, '{sel:4'd2, data:8'd255, z:1'b0, c:1'b1}, w);
    @(negedge clk); io.issue_valid = 1'b0;
    check("sub_b2b_sel", {28'd0, io.wb_sel}, 32'd2);
    idle(1);

    // MUL: 8 busy cycles, operands scrambled after accept
    issue(3'd7, 4'd4, 8'd20, 8'd13, 1, '{sel:4'd4, data:8'd4, z:1'b0, c:1'b1}, w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      io.issue_valid = 1'b0; io.a = 8'hFF; io.b = 8'hFF;
      check("mul_busy",  {31'd0, io.busy},        32'd1);
      check("mul_ready", {31'd0, io.issue_ready}, 32'd0);
    end
    @(negedge clk);
    check("mul_wb_we", {31'd0, io.wb_we}, 32'd1);
    check("mul_busy_done", {31'd0, io.busy}, 32'd0);
    issue(3'd7, 4'd5, 8'd15, 8'd17, 1, '{sel:4'd5, data:8'd255, z:1'b0, c:1'b0}, w);
    idle(10);

    // ADD held during MUL is accepted in the WB cycle
    issue(3'd7, 4'd6, 8'd3, 8'd4, 1, '{sel:4'd6, data:8'd12, z:1'b0, c:1'b0}, w);
    issue(3'd0, 4'd7, 8'd1, 8'd1, 1, '{sel:4'd7, data:8'd2, z:1'b0, c:1'b0}, w);
    check("held_add_wait", w, 32'd8);
    @(negedge clk); io.issue_valid = 1'b0;
    check("held_add_wb_sel", {28'd0, io.wb_sel}, 32'd7);
    idle(1);

    // shifts, logic ops, edge values, all back-to-back
    issue(3'd5, 4'd8,  8'h81, 8'h01, 1, '{sel:4'd8,  data:8'h02, z:1'b0, c:1'b1}, w);
    issue(3'd6, 4'd9,  8'h81, 8'h09, 1, '{sel:4'd9,  data:8'h40, z:1'b0, c:1'b1}, w);
    issue(3'd5, 4'd10, 8'h55, 8'h08, 1, '{sel:4'd10, data:8'h55, z:1'b0, c:1'b0}, w);
    issue(3'd2, 4'd11, 8'hF0, 8'h0F, 1, '{sel:4'd11, data:8'h00, z:1'b1, c:1'b0}, w);
    issue(3'd3, 4'd12, 8'hF0, 8'h0F, 1, '{sel:4'd12, data:8'hFF, z:1'b0, c:1'b0}, w);
    issue(3'd4, 4'd13, 8'hAA, 8'hAA, 1, '{sel:4'd13, data:8'h00, z:1'b1, c:1'b0}, w);
    issue(3'd6, 4'd14, 8'h01, 8'h01, 1, '{sel:4'd14, data:8'h00, z:1'b1, c:1'b1}, w);
    issue(3'd7, 4'd15, 8'd0,  8'd200, 1, '{sel:4'd15, data:8'h00, z:1'b1, c:1'b0}, w);
    issue(3'd0, 4'd0,  8'd255, 8'd1, 1, '{sel:4'd0,  data:8'h00, z:1'b1, c:1'b1}, w);
    idle(2);

    // random mix against the reference model
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7)); ra = 8'($urandom); rb = 8'($urandom);
      e = model(ro, 4'(i), ra, rb);
      issue(ro, 4'(i), ra, rb, 1, e, w);
    end
    idle(12);

    // reset 3 cycles into a MUL aborts it
    issue(3'd7, 4'd9, 8'd20, 8'd13, 0, '{sel:4'd0, data:8'd0, z:1'b0, c:1'b0}, w);
    @(negedge clk); io.issue_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy",    {31'd0, io.busy},        32'd0);
    check("abort_ready",   {31'd0, io.issue_ready}, 32'd1);
    check("abort_wb_data", {24'd0, io.wb_data},     32'd0);
    check("abort_flag_z",  {31'd0, io.flag_z},      32'd0);
    check("abort_flag_c",  {31'd0, io.flag_c},      32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_ready", {31'd0, io.issue_ready}, 32'd1);
    check("post_rst_wb_we", {31'd0, io.wb_we},       32'd0);
    issue(3'd0, 4'd5, 8'd1, 8'd2, 1, '{sel:4'd5, data:8'd3, z:1'b0, c:1'b0}, w);
    idle(3);
    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter: MUL_CYCLES, default 8, number of iteration cycles for MUL (fixed at 8 for 8-bit operands; other values illegal).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 issue_valid  input  1  upstream presents an operation this cycle.
REQ-005 issue_ready  output  1  unit can accept an operation this cycle.
REQ-006 op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
REQ-007 rd  input  4  destination register index.
REQ-008 a  input  8  operand A (register-file read port 1 value).
REQ-009 b  input  8  operand B (register-file read port 2 value).
REQ-010 wb_we  output  1  register-file write enable, one-cycle pulse per completed op.
REQ-011 wb_sel  output  4  register-file write index.
REQ-012 wb_data  output  8  register-file write data.
REQ-013 flag_z  output  1  result of last completed op was zero.
REQ-014 flag_c  output  1  carry/borrow/overflow of last completed op.
REQ-015 busy  output  1  MUL in progress.

Function
REQ-016 Accept = issue_valid & issue_ready at a rising edge; op, rd, a, b captured only on accept.
REQ-017 FSM states: IDLE, WB, MUL; issue_ready = 1 in IDLE and WB, 0 in MUL; busy = 1 only in MUL.
REQ-018 IDLE/WB: accept of op 0-6 -> WB; accept of MUL -> MUL; no accept -> IDLE.
REQ-019 WB: wb_we = 1, wb_sel = captured rd, wb_data = result, for exactly one cycle; wb_we = 0 in IDLE and MUL.
REQ-020 ALU latency: op accepted at edge E0 -> wb_we high between E0 and E1; back-to-back accepts give one writeback per cycle, no bubbles.
REQ-021 ADD: 9-bit a+b; wb_data = low 8 bits, flag_c = bit 8 (mod-256 wrap).
REQ-022 SUB: a-b mod 256; flag_c = 1 iff a < b (borrow).
REQ-023 AND/OR/XOR: bitwise; flag_c = 0.
REQ-024 SHL: a shifted left by b[2:0]; flag_c = last bit shifted out (0 if b[2:0]=0); b[7:3] ignored.
REQ-025 SHR: logical right shift of a by b[2:0]; flag_c = last bit shifted out (0 if b[2:0]=0).
REQ-026 MUL: iterative shift-add, one multiplier bit per cycle, MUL_CYCLES cycles; accepted at E0 -> MUL for edges E1..E8 -> WB, wb_we high between E8 and E9.
REQ-027 MUL: wb_data = low byte of 16-bit product; flag_c = 1 iff high byte nonzero.
REQ-028 flag_z = (wb_data == 0); flag_z and flag_c update only on the edge entering WB and hold until next writeback.
REQ-029 issue_valid during MUL is not accepted; upstream must hold op, rd, a, b stable until accepted.
REQ-030 Operand changes after accept have no effect on the in-flight op.

Reset
REQ-031 rst_n low -> immediately: state IDLE, wb_we 0, wb_sel 0, wb_data 0, flag_z 0, flag_c 0, busy 0, multiplier datapath cleared; issue_ready 1 while rst_n low.
REQ-032 Reset during MUL or WB aborts the op; no writeback occurs for it after rst_n rises.
REQ-033 First accept possible at first rising edge with rst_n high.

Verification
REQ-034 ADD a=200 b=100 rd=3 -> next cycle wb_we=1, wb_sel=3, wb_data=44, flag_c=1, flag_z=0; following cycle wb_we=0.
REQ-035 SUB a=5 b=5 rd=1 then, back-to-back, SUB a=2 b=3 rd=2 -> consecutive cycles: (1, 0, z=1, c=0) then (2, 255, z=0, c=1).
REQ-036 MUL a=20 b=13 rd=4 -> busy/issue_ready=0 for 8 cycles, then wb_data=4, wb_sel=4, flag_c=1; MUL a=15 b=17 -> wb_data=255, flag_c=0.
REQ-037 issue_valid held with ADD a=1 b=1 during MUL -> not accepted until WB cycle, writeback wb_data=2 one cycle after MUL writeback.
REQ-038 SHL a=0x81 b=1 -> wb_data=0x02, flag_c=1; SHR a=0x81 b=0x09 -> wb_data=0x40, flag_c=1 (shift by 1).
REQ-039 rst_n pulsed low 3 cycles into MUL -> outputs cleared immediately, no wb_we after release, issue_ready=1.
